reset_seq: RTL

//  Downstream of the power-on reset counter. Takes its delayed reset_n and a PLL lock flag.

---
 rtl/reset_seq_if.sv | 24 ++
 rtl/reset_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/reset_seq_if.sv
// Bundle of the reset sequencer's lock/soft-reset inputs and its sequenced outputs.
// The master side drives the lock and request lines; the slave side is the sequencer.
interface reset_seq_if #(
  parameter int NUM_RST = 4
);
  logic               pll_locked;
  logic               soft_rst_req;
  logic [NUM_RST-1:0] rst_n_out;
  logic               seq_done;

  modport master (
    output pll_locked,
    output soft_rst_req,
    input  rst_n_out,
    input  seq_done
  );

  modport slave (
    input  pll_locked,
    input  soft_rst_req,
    output rst_n_out,
    output seq_done
  );
endinterface

// File: rtl/reset_seq.sv
// Reset sequencer: waits for a filtered PLL lock, then releases NUM_RST active-low
// resets one at a time (bit 0 first) with GAP_CYCLES between releases. Lock loss
// drops everything and restarts from lock filtering; a soft reset request holds all
// outputs low for HOLD_CYCLES and then re-sequences.
// Optional feature: define RESET_SEQ_LOCK_CNT_EN to add the saturating 8-bit
// lock_loss_cnt output counting lock-loss aborts.
module reset_seq #(
  parameter int NUM_RST     = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_FILTER = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int HOLD_CYCLES = 32
) (
  input  logic        tx_clk,
  input  logic        reset_n_in,
  reset_seq_if.slave  bus
`ifdef RESET_SEQ_LOCK_CNT_EN
  ,
  output logic [7:0]  lock_loss_cnt
`endif
);

  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [NUM_RST-1:0] rst_n_r;
  logic               seq_done_r;
  logic [1:0]         lock_sync_r;
  logic               lock_s;

  assign lock_s = lock_sync_r[1];

  // Two-flop synchroniser bringing the asynchronous PLL lock into tx_clk.
  always_ff @(posedge tx_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      lock_sync_r <= 2'b00;
    end else begin
      lock_sync_r <= {lock_sync_r[0], bus.pll_locked};
    end
  end

  // Sequencer FSM: lock loss beats soft reset, which beats the counter events.
  always_ff @(posedge tx_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r    <= WAIT_LOCK;
      cnt_r      <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      rst_n_r    <= {NUM_RST{1'b0}};
      seq_done_r <= 1'b0;
    end else if ((state_r != WAIT_LOCK) && !lock_s) begin
      state_r    <= WAIT_LOCK;
      cnt_r      <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      rst_n_r    <= {NUM_RST{1'b0}};
      seq_done_r <= 1'b0;
    end else if (bus.soft_rst_req && ((state_r == RELEASE) || (state_r == DONE))) begin
      state_r    <= HOLD;
      cnt_r      <= {CNT_W{1'b0}};
      rst_n_r    <= {NUM_RST{1'b0}};
      seq_done_r <= 1'b0;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          // The filter count restarts whenever the synchronised lock dips.
          if (!lock_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (cnt_r == LOCK_LAST) begin
            state_r <= RELEASE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_r == GAP_LAST) begin
            for (int i = 0; i < NUM_RST; i++) begin
              if (idx_r == IDX_W'(i)) begin
                rst_n_r[i] <= 1'b1;
              end
            end
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= idx_r + IDX_W'(1);
            if (idx_r == IDX_LAST) begin
              state_r    <= DONE;
              seq_done_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          seq_done_r <= 1'b1;
        end
        HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_r <= RELEASE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= WAIT_LOCK;
          cnt_r      <= {CNT_W{1'b0}};
          idx_r      <= {IDX_W{1'b0}};
          rst_n_r    <= {NUM_RST{1'b0}};
          seq_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_n_out = rst_n_r;
  assign bus.seq_done  = seq_done_r;

`ifdef RESET_SEQ_LOCK_CNT_EN
  logic [7:0] lock_loss_cnt_r;

  // Saturating count of sequences aborted by lock loss; only reset_n_in clears it.
  always_ff @(posedge tx_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      lock_loss_cnt_r <= 8'd0;
    end else if ((state_r != WAIT_LOCK) && !lock_s && (lock_loss_cnt_r != 8'd255)) begin
      lock_loss_cnt_r <= lock_loss_cnt_r + 8'd1;
    end
  end

  assign lock_loss_cnt = lock_loss_cnt_r;
`endif

endmodule
